cop0_irq_controller: RTL

Interrupt front end for the multicycle MIPS core: the source side of the COP0 interrupt interface. It synchronizes the eight external interrupt request lines, latches edge-type requests, and drives the pending vector into COP0. It watches the masked interrupt vector COP0 returns and runs a request/acknowledge handshake with the control FSM. It emits the one-cycle `oInterrupted` pulse that COP0 uses to retire the COUNT/COMPARE interrupt.

---
 rtl/cop0_irq_controller.sv | 109 ++++++++++
 1 files changed

// File: rtl/cop0_irq_controller.sv
// Interrupt front end for the multicycle MIPS core: synchronizes and latches the
// external IRQ lines, feeds the pending vector to COP0 and handshakes with the control FSM.
module cop0_irq_controller #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] EDGE_LINES  = 8'b1111_1000
) (
    input  logic       iCLK,
    input  logic       iCLR_n,
    input  logic [7:0] iIRQ,
    input  logic [7:0] iInterruptMask,
    input  logic       iExcLevel,
    input  logic       iIntAck,
    input  logic       iEret,
    input  logic [7:0] iClearPending,
    output logic [7:0] oPendingInterrupt,
    output logic       oIntRequest,
    output logic       oInterrupted,
    output logic [2:0] oIntLine,
    output logic [4:0] oExcCode
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;
    localparam logic [1:0] S_SERVICE = 2'd3;

    // Line 2 belongs to COUNT/COMPARE inside COP0, so the external pin is dropped here.
    localparam logic [7:0] EXT_LINES = 8'b1111_1011;

    logic [SYNC_STAGES-1:0][7:0] r_sync;
    logic [7:0] w_s, r_prev, r_lat, r_pend;
    logic [7:0] w_set, w_clr, w_lat_nxt;
    logic [1:0] r_state, w_state_nxt;
    logic       r_req, r_intd;
    logic [2:0] r_line, w_win;
    logic       w_reqable, w_take;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge iCLK or negedge iCLR_n) begin
        if (!iCLR_n) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], iIRQ & EXT_LINES};
            r_prev <= w_s;
        end
    end

    always_comb begin
        w_win = 3'd0;
        for (int i = 0; i < 8; i++)
            if (iInterruptMask[i]) w_win = 3'(i);
    end

    assign w_reqable = (iInterruptMask != 8'd0) && !iExcLevel;
    assign w_take    = (r_state == S_REQ) && iIntAck && (iInterruptMask != 8'd0);

    // Edge latches: a fresh rising edge beats any clear in the same cycle.
    assign w_set     = w_s & ~r_prev & EDGE_LINES;
    assign w_clr     = iClearPending | (w_take ? (8'd1 << w_win) : 8'd0);
    assign w_lat_nxt = (EDGE_LINES & (w_set | (r_lat & ~w_clr))) | (~EDGE_LINES & w_s);

    always_ff @(posedge iCLK or negedge iCLR_n) begin
        if (!iCLR_n) begin
            r_lat  <= '0;
            r_pend <= '0;
        end else begin
            r_lat  <= w_lat_nxt;
            r_pend <= r_lat & EXT_LINES;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_reqable) w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_take)          w_state_nxt = S_ACK;
                else if (!w_reqable) w_state_nxt = S_IDLE;
            end
            S_ACK:     w_state_nxt = S_SERVICE;
            // A software clear of EL releases the block just like eret.
            S_SERVICE: if (iEret || !iExcLevel) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iCLR_n) begin
        if (!iCLR_n) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_intd  <= 1'b0;
            r_line  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= (w_state_nxt == S_REQ);
            r_intd  <= (w_state_nxt == S_ACK);
            if (w_take) r_line <= w_win;
        end
    end

    assign oPendingInterrupt = r_pend;
    assign oIntRequest       = r_req;
    assign oInterrupted      = r_intd;
    assign oIntLine          = r_line;
    assign oExcCode          = 5'd0;

endmodule
